// File: rtl/crc_mon_pkg.sv
// rtl/crc_mon_pkg.sv - shared types, widths and the signature rotate helper for crc_result_monitor
package crc_mon_pkg;

    localparam int CNT_W = 8;
    localparam int CRC_W = 32;

    typedef logic [CRC_W-1:0] crc_t;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic crc_t rotl1(input crc_t v);
        return {v[CRC_W-2:0], v[CRC_W-1]};
    endfunction

endpackage

// File: rtl/crc_mon_fifo.sv
// rtl/crc_mon_fifo.sv - synchronous show-ahead FIFO buffering CRC results toward the capture side
module crc_mon_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;

    assign do_pop = pop & ~empty;
    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign head   = mem[rd_ptr];

    // Storage carries no reset; head is only meaningful while non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/crc_result_monitor.sv
// rtl/crc_result_monitor.sv - buffers, counts and signs CRC results; optional watchdog under CRC_MON_TIMEOUT_EN
module crc_result_monitor
    import crc_mon_pkg::*;
#(
    parameter int               CRC_WIDTH  = CRC_W,
    parameter int               FIFO_DEPTH = 8,
    parameter logic [CNT_W-1:0] PKT_LIMIT  = 8'd16,
    parameter int               TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CRC_WIDTH-1:0] crc_in,
    input  logic                 crc_in_vld,
    output logic [CRC_WIDTH-1:0] m_crc,
    output logic                 m_vld,
    input  logic                 m_rdy,
    output logic [CNT_W-1:0]     pkt_cnt,
    output logic [CRC_WIDTH-1:0] signature,
    output logic                 done,
    output logic                 overflow
`ifdef CRC_MON_TIMEOUT_EN
    ,
    output logic                 timeout
`endif
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    logic                 counted;
    logic                 pop;
    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CRC_WIDTH-1:0] sig_rot;
    logic [CNT_W-1:0]     cnt_next;

    // Results after done are ignored entirely, including the FIFO.
    assign counted  = crc_in_vld & ~done;
    assign pop      = m_vld & m_rdy;
    assign push     = counted & (~fifo_full | pop);
    assign m_vld    = ~fifo_empty;
    assign cnt_next = pkt_cnt + 1'b1;

    if (CRC_WIDTH == CRC_W) begin : g_sig_pkg
        assign sig_rot = rotl1(signature);
    end else begin : g_sig_generic
        assign sig_rot = {signature[CRC_WIDTH-2:0], signature[CRC_WIDTH-1]};
    end

    crc_mon_fifo #(
        .WIDTH (CRC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (crc_in),
        .pop       (pop),
        .head      (m_crc),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt   <= '0;
            signature <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else if (counted) begin
            pkt_cnt   <= cnt_next;
            signature <= sig_rot ^ crc_in;
            // A zero limit means run forever, even when the counter wraps to 0.
            if (PKT_LIMIT != '0 && cnt_next == PKT_LIMIT) begin
                done <= 1'b1;
            end
            if (fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef CRC_MON_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_next;

    // Armed only once a result has been counted, so a long idle start is harmless.
    always_comb begin
        wd_next = wd_cnt;
        if (crc_in_vld) begin
            wd_next = '0;
        end else if (!done && pkt_cnt != '0 && wd_cnt != WD_MAX) begin
            wd_next = wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            wd_cnt <= wd_next;
            if (wd_next == WD_MAX) begin
                timeout <= 1'b1;
            end
        end
    end
`endif

endmodule
